guest_spi_responder: RTL and testbench
======================================

# guest_spi_responder

Guest-core side of the controller-to-core SPI link: an SPI mode-0 target that decodes command packets sent by the substitute MCU on the CONF_DATA0-selected channel. It updates the core-visible registers for buttons/switches, joysticks and the 32-bit status word, and queues PS/2 keyboard bytes in a small FIFO. It also returns the core ID and, optionally, the configuration string. It sits inside the guest core, with its pins wired to SPI_SCK, SPI_DI, SPI_DO and CONF_DATA0.

## Interface
- CORE_ID, 8'hA4, byte returned on MISO during every command byte
- CONF_ADDR_W, 10, width of the config-string address
- FIFO_DEPTH_LOG2, 3, keyboard FIFO depth = 2**FIFO_DEPTH_LOG2

- clk  in  1  system clock, ≥ 6× SPI clock
- reset_n  in  1  synchronous, active-low reset
- spi_sck  in  1  SPI clock, asynchronous to clk
- spi_ss_n  in  1  CONF_DATA0, active-low packet select
- spi_mosi  in  1  data from MCU (SPI_DI)
- spi_miso  out  1  data to MCU (SPI_DO)
- spi_miso_oe  out  1  high while spi_ss_n is low (synchronised)
- buttons  out  2  from cmd 0x01 bits [1:0]
- switches  out  2  from cmd 0x01 bits [3:2]
- joy0, joy1  out  8 each  from cmd 0x02 and cmd 0x03
- status  out  32  from cmd 0x1E
- ps2k_data  out  8  FIFO head byte
- ps2k_valid  out  1  FIFO not empty
- ps2k_ready  in  1  pop the head when valid && ready
- ps2k_ovf  out  1  sticky flag: a byte was dropped
- conf_addr  out  CONF_ADDR_W  config ROM address
- conf_data  in  8  ROM data, one clk of latency

## Operation
- **Input sync:** spi_sck, spi_ss_n and spi_mosi each pass through 2 flops. A third flop on sck gives rise and fall strobes.
- **Bit timing (mode 0):** MOSI is sampled on the sck rise strobe, MSB first. The MISO shift register advances on the fall strobe.
- **FSM states:** IDLE, CMD, DATA.
  - IDLE → CMD when synchronised ss_n falls. This clears bit_cnt (3 b) and byte_idx (saturating at CONF_ADDR_W bits), and preloads the MISO shifter with CORE_ID.
  - CMD: on the 8th rise, latch cmd and go to DATA.
  - DATA: each 8th rise completes a byte, executes the command action, then increments byte_idx.
  - Any state → IDLE when synchronised ss_n is high. A partial byte is discarded and no register changes.
- **Command actions, on completed byte n (0-based after the command byte):**
  - 0x01, n=0: buttons ← b[1:0], switches ← b[3:2].
  - 0x02, n=0: joy0 ← b. 0x03, n=0: joy1 ← b. Later bytes of these commands are ignored.
  - 0x05, each n: push b into the keyboard FIFO.
  - 0x1E, n=0..3: assemble into a shadow register, LSB byte first. status ← shadow only when n=3 completes. A packet aborted earlier leaves status unchanged. Bytes after n=3 are ignored.
  - 0x14: config-string read (see Configuration). Incoming bytes are ignored.
  - Any other command: bytes ignored, MISO returns 0x00.
- **MISO reload:** on the fall strobe following a completed byte, the shifter loads the next return byte. That byte is conf_data for 0x14, otherwise 0x00.
- **FIFO:**
  - Push while full is dropped and sets ps2k_ovf, unless a pop happens in the same cycle, in which case the push is accepted.
  - Pop while empty has no effect.
  - ps2k_ovf clears only on reset.

## Timing
- Reset values: all outputs 0. FIFO empty. FSM in IDLE.
- Register update latency: the output register changes 4 clk cycles after the SCK edge at the pin (2 sync + edge detect + register).
- ps2k_valid rises 1 clk after the push. ps2k_data is stable while valid && !ready.
- conf_addr is driven from byte_idx as soon as cmd 0x14 is latched, and on each byte_idx increment. conf_data is sampled 1 clk later, ahead of the next fall strobe.
- Reset mid-packet: all state returns to reset values. The remainder of that packet is ignored until ss_n goes high and then low again.

## Configuration
- Macro: GUEST_SPI_CONF_STR_EN.
  - Defined: cmd 0x14 returns conf_data for addresses 0,1,2,… MSB first, one byte per SPI byte. conf_addr saturates at its maximum.
  - Undefined: cmd 0x14 returns 0x00 bytes, conf_addr is tied to 0, and conf_data is unused.

## Test plan
- Send packet 0x02,0x5A at SCK = clk/8 → spi_miso shifts 0xA4 during the command byte. joy0 = 0x5A within 4 clk of the 16th rise. joy1 is unchanged.
- Send 0x1E,0x78,0x56 then raise ss_n; then send 0x1E,0x78,0x56,0x34,0x12 → status stays 0 after the first packet and equals 0x12345678 after the second.
- Send 0x05 followed by 9 bytes 0x10..0x18 with ps2k_ready = 0 → FIFO holds 0x10..0x17 and ps2k_ovf = 1. Then hold ready high → bytes pop in order and valid drops after 8 pops.
- Raise ss_n after 5 bits of a 0x01 data byte → buttons and switches stay at 0. The next full packet 0x01,0x0F gives buttons = 3, switches = 3.
- With GUEST_SPI_CONF_STR_EN defined and ROM holding "AB", send 0x14 followed by 2 dummy bytes → MISO returns 0x41, 0x42 and conf_addr steps 0 → 1 → 2. With the macro undefined, MISO returns 0x00, 0x00.
- Assert reset_n = 0 for 1 clk mid-packet → all outputs read 0 on the next cycle. The remaining bytes of that packet are ignored.

Source files
------------

// File: rtl/guest_spi_responder_if.sv
// rtl/guest_spi_responder_if.sv - SPI pin bundle between the MCU (master) and the guest core (slave)
//
// Signals:
//   spi_sck      SPI clock driven by the MCU
//   spi_ss_n     CONF_DATA0, active-low packet select
//   spi_mosi     SPI_DI, MCU to core
//   spi_miso     SPI_DO, core to MCU
//   spi_miso_oe  core drives spi_miso while a packet is selected

interface guest_spi_responder_if;
  logic spi_sck;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sck,
    output spi_ss_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sck,
    input  spi_ss_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/guest_spi_responder.sv
// rtl/guest_spi_responder.sv - SPI mode-0 command responder for the guest core
//
// Optional feature macro: GUEST_SPI_CONF_STR_EN (config-string readback on cmd 0x14).
//
// Ports:
//   clk, reset_n        system clock (>= 6x SCK), synchronous active-low reset
//   spi                 SPI pins (slave modport): sck, ss_n, mosi in; miso, miso_oe out
//   buttons, switches   from cmd 0x01
//   joy0, joy1          from cmd 0x02 / 0x03
//   status              32-bit word from cmd 0x1E, committed on the 4th data byte
//   ps2k_data/valid     keyboard FIFO head, popped when valid && ps2k_ready
//   ps2k_ovf            sticky: a keyboard byte was dropped
//   conf_addr/conf_data config ROM port (data has one clk of latency)

module guest_spi_responder #(
  parameter logic [7:0] CORE_ID         = 8'hA4,
  parameter int         CONF_ADDR_W     = 10,
  parameter int         FIFO_DEPTH_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  guest_spi_responder_if.slave   spi,
  output logic [1:0]             buttons,
  output logic [1:0]             switches,
  output logic [7:0]             joy0,
  output logic [7:0]             joy1,
  output logic [31:0]            status,
  output logic [7:0]             ps2k_data,
  output logic                   ps2k_valid,
  input  logic                   ps2k_ready,
  output logic                   ps2k_ovf,
  output logic [CONF_ADDR_W-1:0] conf_addr,
  input  logic [7:0]             conf_data
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [7:0] CMD_BUTTONS = 8'h01;
  localparam logic [7:0] CMD_JOY0    = 8'h02;
  localparam logic [7:0] CMD_JOY1    = 8'h03;
  localparam logic [7:0] CMD_KBD     = 8'h05;
  localparam logic [7:0] CMD_CONF    = 8'h14;
  localparam logic [7:0] CMD_STATUS  = 8'h1E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. ss_n flops reset to 0 so that a reset taken while the
  // MCU holds ss_n low produces no falling edge: the rest of that packet is
  // ignored until ss_n has been seen high and then low again.
  // ---------------------------------------------------------------------------
  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      ss_s1_q   <= 1'b0;
      ss_s2_q   <= 1'b0;
      ss_s3_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= spi.spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      ss_s1_q   <= spi.spi_ss_n;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      mosi_s1_q <= spi.spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic sck_rise, sck_fall, ss_fall;
  assign sck_rise = sck_s2_q & ~sck_s3_q;
  assign sck_fall = ~sck_s2_q & sck_s3_q;
  assign ss_fall  = ss_s3_q & ~ss_s2_q;

  // ---------------------------------------------------------------------------
  // Packet FSM and core-visible registers
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [CONF_ADDR_W-1:0] byte_idx_q;
  logic [7:0]             cmd_q;
  logic [7:0]             shift_in_q;
  logic [7:0]             miso_sh_q;
  logic                   reload_q;    // a byte just completed; next fall loads a fresh return byte
  logic                   miso_oe_q;
  logic [1:0]             buttons_q;
  logic [1:0]             switches_q;
  logic [7:0]             joy0_q;
  logic [7:0]             joy1_q;
  logic [31:0]            status_q;
  logic [23:0]            status_sh_q; // low three bytes of a status word in flight

  logic [7:0] rx_byte;
  logic       byte_end;
  logic       active;
  logic [7:0] next_tx;

  assign rx_byte  = {shift_in_q[6:0], mosi_s2_q};
  assign byte_end = (bit_cnt_q == 3'd7);
  assign active   = (state_q != ST_IDLE) && !ss_s2_q;

`ifdef GUEST_SPI_CONF_STR_EN
  assign next_tx   = (cmd_q == CMD_CONF) ? conf_data : 8'h00;
  // byte_idx saturates, so the ROM address does too.
  assign conf_addr = byte_idx_q;
`else
  logic unused_conf_data;
  assign unused_conf_data = ^conf_data;
  assign next_tx   = 8'h00;
  assign conf_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= '0;
      cmd_q       <= 8'h00;
      shift_in_q  <= 8'h00;
      miso_sh_q   <= 8'h00;
      reload_q    <= 1'b0;
      miso_oe_q   <= 1'b0;
      buttons_q   <= 2'b00;
      switches_q  <= 2'b00;
      joy0_q      <= 8'h00;
      joy1_q      <= 8'h00;
      status_q    <= 32'h0;
      status_sh_q <= 24'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            state_q    <= ST_CMD;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= '0;
            miso_sh_q  <= CORE_ID;
            reload_q   <= 1'b0;
            miso_oe_q  <= 1'b1;
          end
        end
        default: begin
          if (ss_s2_q) begin
            // Deselect: any partial byte is simply dropped.
            state_q   <= ST_IDLE;
            miso_oe_q <= 1'b0;
            miso_sh_q <= 8'h00;
            reload_q  <= 1'b0;
          end else if (sck_rise) begin
            shift_in_q <= rx_byte;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (byte_end) begin
              reload_q <= 1'b1;
              if (state_q == ST_CMD) begin
                cmd_q   <= rx_byte;
                state_q <= ST_DATA;
              end else begin
                case (cmd_q)
                  CMD_BUTTONS: if (byte_idx_q == '0) begin
                    buttons_q  <= rx_byte[1:0];
                    switches_q <= rx_byte[3:2];
                  end
                  CMD_JOY0: if (byte_idx_q == '0) joy0_q <= rx_byte;
                  CMD_JOY1: if (byte_idx_q == '0) joy1_q <= rx_byte;
                  CMD_STATUS: begin
                    if (byte_idx_q < CONF_ADDR_W'(3)) begin
                      status_sh_q[byte_idx_q[1:0]*8 +: 8] <= rx_byte;
                    end else if (byte_idx_q == CONF_ADDR_W'(3)) begin
                      status_q <= {rx_byte, status_sh_q};
                    end
                  end
                  default: ;
                endcase
                if (byte_idx_q != {CONF_ADDR_W{1'b1}}) begin
                  byte_idx_q <= byte_idx_q + 1'b1;
                end
              end
            end
          end else if (sck_fall) begin
            if (reload_q) begin
              miso_sh_q <= next_tx;
              reload_q  <= 1'b0;
            end else begin
              miso_sh_q <= {miso_sh_q[6:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign spi.spi_miso    = miso_sh_q[7];
  assign spi.spi_miso_oe = miso_oe_q;
  assign buttons         = buttons_q;
  assign switches        = switches_q;
  assign joy0            = joy0_q;
  assign joy1            = joy1_q;
  assign status          = status_q;

  // ---------------------------------------------------------------------------
  // Keyboard FIFO. A push into a full FIFO is still accepted when the head is
  // popped in the same cycle.
  // ---------------------------------------------------------------------------
  logic [7:0]                 fifo_mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic                       push, pop, full, accept;

  assign push   = active && (state_q == ST_DATA) && sck_rise && byte_end && (cmd_q == CMD_KBD);
  assign full   = (count_q == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign pop    = (count_q != '0) && ps2k_ready;
  assign accept = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
    if (push && !accept)     ovf_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (accept) fifo_mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign ps2k_valid = (count_q != '0);
  assign ps2k_data  = ps2k_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
  assign ps2k_ovf   = ovf_q;

endmodule

// File: tb/tb_guest_spi_responder.sv
// tb/tb_guest_spi_responder.sv - directed scoreboard bench for guest_spi_responder

`timescale 1ns/1ps

module tb_guest_spi_responder;

  localparam int HALF_SCK = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] buttons, switches;
  logic [7:0] joy0, joy1;
  logic [31:0] status;
  logic [7:0] ps2k_data;
  logic       ps2k_valid;
  logic       ps2k_ready = 1'b0;
  logic       ps2k_ovf;
  logic [9:0] conf_addr;
  logic [7:0] conf_data = 8'h00;

  guest_spi_responder_if spi_if ();

  guest_spi_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi        (spi_if.slave),
    .buttons    (buttons),
    .switches   (switches),
    .joy0       (joy0),
    .joy1       (joy1),
    .status     (status),
    .ps2k_data  (ps2k_data),
    .ps2k_valid (ps2k_valid),
    .ps2k_ready (ps2k_ready),
    .ps2k_ovf   (ps2k_ovf),
    .conf_addr  (conf_addr),
    .conf_data  (conf_data)
  );

  always #5 clk = ~clk;

  // Config ROM holding "AB", one clk of read latency.
  always @(posedge clk) begin
    case (conf_addr)
      10'd0:   conf_data <= 8'h41;
      10'd1:   conf_data <= 8'h42;
      default: conf_data <= 8'h00;
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_miso_q [$];
  logic [7:0] exp_kbd_q [$];
  logic       exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_mosi = tx[7-i];
      #HALF_SCK;
      rx = {rx[6:0], spi_if.spi_miso};
      spi_if.spi_sck = 1'b1;
      #HALF_SCK;
      spi_if.spi_sck = 1'b0;
    end
    #HALF_SCK;
  endtask

  // Full byte: expected MISO byte goes to the scoreboard, received byte is popped against it.
  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] exp_rx);
    logic [7:0] rx;
    exp_miso_q.push_back(exp_rx);
    spi_bits(tx, 8, rx);
    if (exp_miso_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, {24'h0, rx}, {24'h0, exp_miso_q.pop_front()});
  endtask

  task automatic kbd_byte(input logic [7:0] b);
    if (exp_kbd_q.size() < 8) exp_kbd_q.push_back(b);
    else exp_ovf = 1'b1;
    xfer("miso_kbd", b, 8'h00);
  endtask

  task automatic ss_low;
    spi_if.spi_ss_n = 1'b0;
    #(2*HALF_SCK);
  endtask

  task automatic ss_high;
    spi_if.spi_ss_n = 1'b1;
    #(2*HALF_SCK);
  endtask

  logic [7:0] conf_exp0, conf_exp1;
  logic [9:0] conf_exp_addr;

  initial begin
    int pops;
    logic [7:0] dummy;
`ifdef GUEST_SPI_CONF_STR_EN
    conf_exp0 = 8'h41; conf_exp1 = 8'h42; conf_exp_addr = 10'd2;
`else
    conf_exp0 = 8'h00; conf_exp1 = 8'h00; conf_exp_addr = 10'd0;
`endif
    spi_if.spi_sck  = 1'b0;
    spi_if.spi_ss_n = 1'b1;
    spi_if.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_outputs", {buttons, switches, joy0, joy1, ps2k_valid, ps2k_ovf, spi_if.spi_miso_oe},
          {4'h0, 16'h0, 3'b000});
    check("rst_status", status, 32'h0);
    check("rst_conf_addr", {22'h0, conf_addr}, 32'h0);

    // Joystick 0
    ss_low();
    check("miso_oe_active", {31'h0, spi_if.spi_miso_oe}, 32'd1);
    xfer("miso_core_id", 8'h02, 8'hA4);
    xfer("miso_joy0_data", 8'h5A, 8'h00);
    check("joy0", {24'h0, joy0}, 32'h5A);
    check("joy1_unchanged", {24'h0, joy1}, 32'h0);
    ss_high();
    check("miso_oe_idle", {31'h0, spi_if.spi_miso_oe}, 32'd0);

    // Status: aborted after two bytes, then complete
    ss_low();
    xfer("miso_st1_cmd", 8'h1E, 8'hA4);
    xfer("miso_st1_b0", 8'h78, 8'h00);
    xfer("miso_st1_b1", 8'h56, 8'h00);
    ss_high();
    check("status_aborted", status, 32'h0);
    ss_low();
    xfer("miso_st2_cmd", 8'h1E, 8'hA4);
    xfer("miso_st2_b0", 8'h78, 8'h00);
    xfer("miso_st2_b1", 8'h56, 8'h00);
    xfer("miso_st2_b2", 8'h34, 8'h00);
    check("status_before_last", status, 32'h0);
    xfer("miso_st2_b3", 8'h12, 8'h00);
    ss_high();
    check("status_full", status, 32'h12345678);

    // Keyboard FIFO overflow and drain
    ss_low();
    xfer("miso_kbd_cmd", 8'h05, 8'hA4);
    for (int i = 0; i < 9; i++) kbd_byte(8'h10 + 8'(i));
    ss_high();
    check("kbd_valid", {31'h0, ps2k_valid}, 32'd1);
    check("kbd_ovf", {31'h0, ps2k_ovf}, {31'h0, exp_ovf});
    @(negedge clk);
    ps2k_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 20; c++) begin
      if (!ps2k_valid) break;
      if (exp_kbd_q.size() == 0) check("kbd_extra_pop", 32'd1, 32'd0);
      else check("kbd_data", {24'h0, ps2k_data}, {24'h0, exp_kbd_q.pop_front()});
      pops++;
      @(negedge clk);
    end
    ps2k_ready = 1'b0;
    check("kbd_pops", pops, 32'd8);
    check("kbd_empty_after", {31'h0, ps2k_valid}, 32'd0);

    // Buttons: partial byte discarded, then a full packet
    ss_low();
    xfer("miso_btn1_cmd", 8'h01, 8'hA4);
    spi_bits(8'h0F, 5, dummy);
    ss_high();
    check("btn_partial", {28'h0, buttons, switches}, 32'h0);
    ss_low();
    xfer("miso_btn2_cmd", 8'h01, 8'hA4);
    xfer("miso_btn2_data", 8'h0F, 8'h00);
    ss_high();
    check("btn_full", {28'h0, buttons, switches}, 32'hF);

    // Config string
    ss_low();
    xfer("miso_conf_cmd", 8'h14, 8'hA4);
    xfer("miso_conf_b0", 8'h00, conf_exp0);
    xfer("miso_conf_b1", 8'h00, conf_exp1);
    check("conf_addr_end", {22'h0, conf_addr}, {22'h0, conf_exp_addr});
    ss_high();

    // Reset pulse mid-packet
    ss_low();
    xfer("miso_rst_cmd", 8'h03, 8'hA4);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_outputs", {buttons, switches, joy0, joy1, ps2k_valid, ps2k_ovf, spi_if.spi_miso_oe},
          {4'h0, 16'h0, 3'b000});
    check("midrst_status", status, 32'h0);
    spi_bits(8'h77, 8, dummy);
    ss_high();
    check("midrst_ignored", {24'h0, joy1}, 32'h0);
    ss_low();
    xfer("miso_post_rst_cmd", 8'h03, 8'hA4);
    xfer("miso_post_rst_data", 8'h33, 8'h00);
    ss_high();
    check("joy1_after_rst", {24'h0, joy1}, 32'h33);
    check("sb_drained", exp_miso_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
